// File: rtl/csr_file_pkg.sv
// Shared CSR addresses, write masks, field positions and small helpers
// for the write-back CSR file and its timer.
package csr_file_pkg;

    localparam logic [13:0] CSR_CRMD   = 14'h0000;
    localparam logic [13:0] CSR_PRMD   = 14'h0001;
    localparam logic [13:0] CSR_ECFG   = 14'h0004;
    localparam logic [13:0] CSR_ESTAT  = 14'h0005;
    localparam logic [13:0] CSR_ERA    = 14'h0006;
    localparam logic [13:0] CSR_BADV   = 14'h0007;
    localparam logic [13:0] CSR_EENTRY = 14'h000C;
    localparam logic [13:0] CSR_TLBEHI = 14'h0011;
    localparam logic [13:0] CSR_SAVE0  = 14'h0030;
    localparam logic [13:0] CSR_SAVE1  = 14'h0031;
    localparam logic [13:0] CSR_SAVE2  = 14'h0032;
    localparam logic [13:0] CSR_SAVE3  = 14'h0033;
    localparam logic [13:0] CSR_TID    = 14'h0040;
    localparam logic [13:0] CSR_TCFG   = 14'h0041;
    localparam logic [13:0] CSR_TVAL   = 14'h0042;
    localparam logic [13:0] CSR_TICLR  = 14'h0044;
    localparam logic [13:0] CSR_LLBCTL = 14'h0060;

    localparam logic [31:0] CRMD_WMASK   = 32'h0000_01FF;
    localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
    localparam logic [31:0] ECFG_WMASK   = 32'h0000_1BFF;
    localparam logic [31:0] EENTRY_WMASK = 32'hFFFF_FFC0;
    localparam logic [31:0] TLBEHI_WMASK = 32'hFFFF_E000;

    localparam int CRMD_DA       = 3;
    localparam int CRMD_PG       = 4;
    localparam int CRMD_IE       = 2;
    localparam int TICLR_CLR     = 0;
    localparam int LLBCTL_WCLLB  = 1;
    localparam int LLBCTL_KLO    = 2;
    localparam int TCFG_EN       = 0;
    localparam int TCFG_PERIODIC = 1;

    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    typedef enum logic [1:0] {
        EVT_NONE = 2'd0,
        EVT_EXCP = 2'd1,
        EVT_ERTN = 2'd2
    } csr_evt_t;

    typedef enum logic {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } tmr_state_t;

    function automatic logic [31:0] csr_wmask(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    // An exception commit shadows a simultaneous ERTN.
    function automatic csr_evt_t csr_evt_decode(input logic excp, input logic ertn);
        csr_evt_t evt;
        if (excp) begin
            evt = EVT_EXCP;
        end else if (ertn) begin
            evt = EVT_ERTN;
        end else begin
            evt = EVT_NONE;
        end
        return evt;
    endfunction

endpackage

// File: rtl/csr_timer.sv
// Stable timer: holds TCFG, counts TVAL down in RUN and raises a one-cycle
// set pulse for ESTAT.IS[11] on the edge where TVAL goes 1 -> 0.
module csr_timer #(
    parameter int TIMER_W = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_tcfg_we,
    input  logic [31:0]        i_tcfg_wdata,
    output logic [31:0]        o_tcfg,
    output logic [TIMER_W-1:0] o_tval,
    output logic               o_timer_set
);
    import csr_file_pkg::*;

    localparam logic [TIMER_W-1:0] TV_ZERO = {TIMER_W{1'b0}};
    localparam logic [TIMER_W-1:0] TV_ONE  = TIMER_W'(1);

    tmr_state_t          r_state;
    logic [31:0]         r_tcfg;
    logic [TIMER_W-1:0]  r_tval;

    logic [TIMER_W-1:0]  w_load_val;
    logic [TIMER_W-1:0]  w_reload_val;
    logic                w_tval_one;
    logic                w_tval_zero;

    assign w_load_val   = {i_tcfg_wdata[TIMER_W-1:2], 2'b00};
    assign w_reload_val = {r_tcfg[TIMER_W-1:2], 2'b00};
    assign w_tval_one   = (r_tval == TV_ONE);
    assign w_tval_zero  = (r_tval == TV_ZERO);

    // Timer FSM; a TCFG write restarts the counter and overrides any tick.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= TMR_IDLE;
            r_tcfg  <= 32'h0000_0000;
            r_tval  <= TV_ZERO;
        end else if (i_tcfg_we) begin
            r_tcfg  <= i_tcfg_wdata;
            r_tval  <= w_load_val;
            r_state <= (i_tcfg_wdata[TCFG_EN] && (w_load_val != TV_ZERO)) ? TMR_RUN : TMR_IDLE;
        end else begin
            case (r_state)
                TMR_RUN: begin
                    if (w_tval_one) begin
                        r_tval  <= TV_ZERO;
                        r_state <= r_tcfg[TCFG_PERIODIC] ? TMR_RUN : TMR_IDLE;
                    end else if (w_tval_zero) begin
                        r_tval  <= w_reload_val;
                    end else begin
                        r_tval  <= r_tval - TV_ONE;
                    end
                end
                TMR_IDLE: begin
                    r_tval  <= r_tval;
                end
                default: begin
                    r_state <= TMR_IDLE;
                end
            endcase
        end
    end

    assign o_tcfg      = r_tcfg;
    assign o_tval      = r_tval;
    assign o_timer_set = (r_state == TMR_RUN) && w_tval_one && !i_tcfg_we;

endmodule

// File: rtl/csr_file.sv
// Architectural CSR file at the end of WB: masked software writes, exception
// and ERTN field updates, interrupt sampling, LL/SC bit and timer.
module csr_file #(
    parameter int TIMER_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [13:0] waddr,
    input  logic [31:0] wdata,
    input  logic [13:0] raddr,
    output logic [31:0] rdata,
    input  logic        excp_flush,
    input  logic        ertn_flush,
    input  logic [5:0]  ecode,
    input  logic [8:0]  esubcode,
    input  logic [31:0] era_i,
    input  logic        va_error,
    input  logic [31:0] bad_va,
    input  logic        excp_tlb,
    input  logic [18:0] excp_tlb_vppn,
    input  logic        excp_tlbrefill,
    input  logic        llbit_we,
    input  logic        llbit_value,
    input  logic [7:0]  hw_int,
    input  logic        ipi,
    output logic [31:0] eentry_o,
    output logic [31:0] era_o,
    output logic [1:0]  plv_o,
    output logic        llbit_o,
    output logic        has_int
);
    import csr_file_pkg::*;

    logic [31:0]        r_crmd;
    logic [31:0]        r_prmd;
    logic [12:0]        r_lie;
    logic [1:0]         r_is_sw;
    logic [7:0]         r_is_hw;
    logic               r_is_timer;
    logic               r_is_ipi;
    logic [5:0]         r_ecode;
    logic [8:0]         r_esubcode;
    logic [31:0]        r_era;
    logic [31:0]        r_badv;
    logic [25:0]        r_eentry;
    logic [18:0]        r_vppn;
    logic [31:0]        r_save [4];
    logic [31:0]        r_tid;
    logic               r_llbit;
    logic               r_klo;

    csr_evt_t           w_evt;
    logic               w_excp;
    logic               w_ertn;
    logic               w_wr_crmd;
    logic               w_wr_prmd;
    logic               w_wr_ecfg;
    logic               w_wr_estat;
    logic               w_wr_era;
    logic               w_wr_badv;
    logic               w_wr_eentry;
    logic               w_wr_tlbehi;
    logic               w_wr_save;
    logic               w_wr_tid;
    logic               w_wr_tcfg;
    logic               w_wr_llbctl;
    logic               w_ticlr;
    logic [31:0]        w_crmd_sw;
    logic [31:0]        w_prmd_sw;
    logic [31:0]        w_crmd_nxt;
    logic [31:0]        w_prmd_nxt;
    logic [12:0]        w_is;
    logic [31:0]        w_estat;
    logic [31:0]        w_llbctl;
    logic [31:0]        w_tcfg;
    logic [TIMER_W-1:0] w_tval;
    logic               w_timer_set;

    assign w_evt  = csr_evt_decode(excp_flush, ertn_flush);
    assign w_excp = (w_evt == EVT_EXCP);
    assign w_ertn = (w_evt == EVT_ERTN);

    assign w_wr_crmd   = we && (waddr == CSR_CRMD);
    assign w_wr_prmd   = we && (waddr == CSR_PRMD);
    assign w_wr_ecfg   = we && (waddr == CSR_ECFG);
    assign w_wr_estat  = we && (waddr == CSR_ESTAT);
    assign w_wr_era    = we && (waddr == CSR_ERA);
    assign w_wr_badv   = we && (waddr == CSR_BADV);
    assign w_wr_eentry = we && (waddr == CSR_EENTRY);
    assign w_wr_tlbehi = we && (waddr == CSR_TLBEHI);
    assign w_wr_save   = we && (waddr[13:2] == CSR_SAVE0[13:2]);
    assign w_wr_tid    = we && (waddr == CSR_TID);
    assign w_wr_tcfg   = we && (waddr == CSR_TCFG);
    assign w_wr_llbctl = we && (waddr == CSR_LLBCTL);
    assign w_ticlr     = we && (waddr == CSR_TICLR) && wdata[TICLR_CLR];

    csr_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_tcfg_we    (w_wr_tcfg),
        .i_tcfg_wdata (wdata),
        .o_tcfg       (w_tcfg),
        .o_tval       (w_tval),
        .o_timer_set  (w_timer_set)
    );

    assign w_crmd_sw = w_wr_crmd ? csr_wmask(r_crmd, wdata, CRMD_WMASK) : r_crmd;
    assign w_prmd_sw = w_wr_prmd ? csr_wmask(r_prmd, wdata, PRMD_WMASK) : r_prmd;

    // CRMD/PRMD next state: software write first, trap events override their fields.
    always_comb begin
        w_crmd_nxt = w_crmd_sw;
        w_prmd_nxt = w_prmd_sw;
        case (w_evt)
            EVT_EXCP: begin
                w_prmd_nxt[2:0] = r_crmd[2:0];
                w_crmd_nxt[2:0] = 3'b000;
                w_crmd_nxt[CRMD_PG:CRMD_DA] = excp_tlbrefill ? 2'b01 : w_crmd_sw[CRMD_PG:CRMD_DA];
            end
            EVT_ERTN: begin
                w_crmd_nxt[2:0] = r_prmd[2:0];
                w_crmd_nxt[CRMD_PG:CRMD_DA] = (r_ecode == ECODE_TLBR) ? 2'b10 : w_crmd_sw[CRMD_PG:CRMD_DA];
            end
            default: begin
                w_crmd_nxt = w_crmd_sw;
                w_prmd_nxt = w_prmd_sw;
            end
        endcase
    end

    // Mode registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_crmd <= 32'h0000_0008;
            r_prmd <= 32'h0000_0000;
        end else begin
            r_crmd <= w_crmd_nxt;
            r_prmd <= w_prmd_nxt;
        end
    end

    // ESTAT: sampled interrupt lines, software IS bits, timer flag and cause.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_sw    <= 2'b00;
            r_is_hw    <= 8'h00;
            r_is_timer <= 1'b0;
            r_is_ipi   <= 1'b0;
            r_ecode    <= 6'h00;
            r_esubcode <= 9'h000;
        end else begin
            r_is_hw  <= hw_int;
            r_is_ipi <= ipi;
            if (w_wr_estat) begin
                r_is_sw <= wdata[1:0];
            end else begin
                r_is_sw <= r_is_sw;
            end
            if (w_timer_set) begin
                r_is_timer <= 1'b1;
            end else if (w_ticlr) begin
                r_is_timer <= 1'b0;
            end else begin
                r_is_timer <= r_is_timer;
            end
            if (w_excp) begin
                r_ecode    <= ecode;
                r_esubcode <= esubcode;
            end else begin
                r_ecode    <= r_ecode;
                r_esubcode <= r_esubcode;
            end
        end
    end

    // Data CSRs; exception-supplied values beat a same-cycle software write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lie    <= 13'h0000;
            r_era    <= 32'h0000_0000;
            r_badv   <= 32'h0000_0000;
            r_eentry <= 26'h000_0000;
            r_vppn   <= 19'h0_0000;
            r_tid    <= 32'h0000_0000;
            for (int i = 0; i < 4; i++) begin
                r_save[i] <= 32'h0000_0000;
            end
        end else begin
            if (w_wr_ecfg) begin
                r_lie <= wdata[12:0] & ECFG_WMASK[12:0];
            end else begin
                r_lie <= r_lie;
            end
            if (w_excp) begin
                r_era <= era_i;
            end else if (w_wr_era) begin
                r_era <= wdata;
            end else begin
                r_era <= r_era;
            end
            if (w_excp && va_error) begin
                r_badv <= bad_va;
            end else if (w_wr_badv) begin
                r_badv <= wdata;
            end else begin
                r_badv <= r_badv;
            end
            if (w_excp && excp_tlb) begin
                r_vppn <= excp_tlb_vppn;
            end else if (w_wr_tlbehi) begin
                r_vppn <= wdata[31:13];
            end else begin
                r_vppn <= r_vppn;
            end
            if (w_wr_eentry) begin
                r_eentry <= wdata[31:6];
            end else begin
                r_eentry <= r_eentry;
            end
            if (w_wr_tid) begin
                r_tid <= wdata;
            end else begin
                r_tid <= r_tid;
            end
            if (w_wr_save) begin
                r_save[waddr[1:0]] <= wdata;
            end
        end
    end

    // LL/SC bit: ERTN (without KLO) > WB llbit update > software clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_llbit <= 1'b0;
            r_klo   <= 1'b0;
        end else begin
            if (w_ertn && !r_klo) begin
                r_llbit <= 1'b0;
            end else if (llbit_we) begin
                r_llbit <= llbit_value;
            end else if (w_wr_llbctl && wdata[LLBCTL_WCLLB]) begin
                r_llbit <= 1'b0;
            end else begin
                r_llbit <= r_llbit;
            end
            if (w_ertn) begin
                r_klo <= 1'b0;
            end else if (w_wr_llbctl) begin
                r_klo <= wdata[LLBCTL_KLO];
            end else begin
                r_klo <= r_klo;
            end
        end
    end

    assign w_is     = {r_is_ipi, r_is_timer, 1'b0, r_is_hw, r_is_sw};
    assign w_estat  = {1'b0, r_esubcode, r_ecode, 3'b000, w_is};
    assign w_llbctl = {29'h0000_0000, r_klo, 1'b0, r_llbit};

    // Combinational read port; TICLR and unmapped addresses read as zero.
    always_comb begin
        rdata = 32'h0000_0000;
        case (raddr)
            CSR_CRMD:   rdata = r_crmd;
            CSR_PRMD:   rdata = r_prmd;
            CSR_ECFG:   rdata = {19'h0_0000, r_lie};
            CSR_ESTAT:  rdata = w_estat;
            CSR_ERA:    rdata = r_era;
            CSR_BADV:   rdata = r_badv;
            CSR_EENTRY: rdata = {r_eentry, 6'b00_0000};
            CSR_TLBEHI: rdata = {r_vppn, 13'h0000} & TLBEHI_WMASK;
            CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
                        rdata = r_save[raddr[1:0]];
            CSR_TID:    rdata = r_tid;
            CSR_TCFG:   rdata = w_tcfg;
            CSR_TVAL:   rdata = 32'(w_tval);
            CSR_LLBCTL: rdata = w_llbctl;
            default:    rdata = 32'h0000_0000;
        endcase
    end

    assign eentry_o = {r_eentry, 6'b00_0000} & EENTRY_WMASK;
    assign era_o    = r_era;
    assign plv_o    = r_crmd[1:0];
    assign llbit_o  = r_llbit;
    assign has_int  = (|(w_is & r_lie)) & r_crmd[CRMD_IE];

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: stimulus pushes expected values into a
// scoreboard, a separate monitor compares on the falling edge.
module tb_csr_file;

    localparam int SEL_RDATA  = 0;
    localparam int SEL_HASINT = 1;
    localparam int SEL_EENTRY = 2;
    localparam int SEL_ERA    = 3;
    localparam int SEL_PLV    = 4;
    localparam int SEL_LLBIT  = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [13:0] waddr;
    logic [31:0] wdata;
    logic [13:0] raddr;
    logic [31:0] rdata;
    logic        excp_flush;
    logic        ertn_flush;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] era_i;
    logic        va_error;
    logic [31:0] bad_va;
    logic        excp_tlb;
    logic [18:0] excp_tlb_vppn;
    logic        excp_tlbrefill;
    logic        llbit_we;
    logic        llbit_value;
    logic [7:0]  hw_int;
    logic        ipi;
    logic [31:0] eentry_o;
    logic [31:0] era_o;
    logic [1:0]  plv_o;
    logic        llbit_o;
    logic        has_int;

    int          q_sel  [$];
    logic [31:0] q_exp  [$];
    string       q_name [$];
    logic        chk_valid;
    int          n_pass;
    int          n_total;

    always #5 clk = ~clk;

    csr_file #(.TIMER_W(32)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .excp_flush(excp_flush), .ertn_flush(ertn_flush),
        .ecode(ecode), .esubcode(esubcode), .era_i(era_i), .va_error(va_error),
        .bad_va(bad_va), .excp_tlb(excp_tlb), .excp_tlb_vppn(excp_tlb_vppn),
        .excp_tlbrefill(excp_tlbrefill), .llbit_we(llbit_we), .llbit_value(llbit_value),
        .hw_int(hw_int), .ipi(ipi), .eentry_o(eentry_o), .era_o(era_o),
        .plv_o(plv_o), .llbit_o(llbit_o), .has_int(has_int)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input int sel, input logic [13:0] addr,
                              input logic [31:0] exp, input string name);
        raddr = addr;
        q_sel.push_back(sel);
        q_exp.push_back(exp);
        q_name.push_back(name);
        chk_valid = 1'b1;
        step();
        chk_valid = 1'b0;
    endtask

    task automatic rd(input logic [13:0] addr, input logic [31:0] exp, input string name);
        expect_out(SEL_RDATA, addr, exp, name);
    endtask

    task automatic wr(input logic [13:0] addr, input logic [31:0] data);
        we = 1'b1;
        waddr = addr;
        wdata = data;
        step();
        we = 1'b0;
    endtask

    task automatic do_excp(input logic [5:0] code, input logic [31:0] pc);
        excp_flush = 1'b1;
        ecode = code;
        era_i = pc;
        step();
        excp_flush = 1'b0;
    endtask

    task automatic do_ertn();
        ertn_flush = 1'b1;
        step();
        ertn_flush = 1'b0;
    endtask

    // Monitor: compare whenever the stimulus presents a check cycle.
    initial begin
        int          sel;
        logic [31:0] exp;
        logic [31:0] act;
        string       name;
        forever begin
            @(negedge clk);
            if (chk_valid) begin
                n_total++;
                if (q_sel.size() == 0) begin
                    $display("FAIL scoreboard_underflow: got empty queue, required an entry");
                end else begin
                    sel  = q_sel.pop_front();
                    exp  = q_exp.pop_front();
                    name = q_name.pop_front();
                    case (sel)
                        SEL_RDATA:  act = rdata;
                        SEL_HASINT: act = {31'd0, has_int};
                        SEL_EENTRY: act = eentry_o;
                        SEL_ERA:    act = era_o;
                        SEL_PLV:    act = {30'd0, plv_o};
                        SEL_LLBIT:  act = {31'd0, llbit_o};
                        default:    act = 32'hxxxx_xxxx;
                    endcase
                    if (act === exp) begin
                        n_pass++;
                    end else begin
                        $display("FAIL %s: got %h required %h", name, act, exp);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_pass = 0; n_total = 0; chk_valid = 1'b0;
        rst = 1'b1; we = 1'b0; waddr = 14'h0; wdata = 32'h0; raddr = 14'h0;
        excp_flush = 1'b0; ertn_flush = 1'b0; ecode = 6'h0; esubcode = 9'h0;
        era_i = 32'h0; va_error = 1'b0; bad_va = 32'h0; excp_tlb = 1'b0;
        excp_tlb_vppn = 19'h0; excp_tlbrefill = 1'b0; llbit_we = 1'b0;
        llbit_value = 1'b0; hw_int = 8'h00; ipi = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        rd(14'h000, 32'h0000_0008, "rst_crmd");
        rd(14'h042, 32'h0000_0000, "rst_tval");
        expect_out(SEL_HASINT, 14'h000, 32'h0, "rst_has_int");
        rd(14'h7FF, 32'h0000_0000, "rst_unmapped");
        expect_out(SEL_EENTRY, 14'h000, 32'h0, "rst_eentry");

        // Exception entry and return
        wr(14'h000, 32'h0000_0007);
        rd(14'h000, 32'h0000_0007, "crmd_write");
        expect_out(SEL_PLV, 14'h000, 32'h3, "plv_after_write");
        do_excp(6'h0B, 32'h1C00_0100);
        rd(14'h000, 32'h0000_0000, "excp_crmd");
        rd(14'h001, 32'h0000_0007, "excp_prmd");
        rd(14'h006, 32'h1C00_0100, "excp_era");
        rd(14'h005, 32'h000B_0000, "excp_estat");
        expect_out(SEL_ERA, 14'h000, 32'h1C00_0100, "excp_era_o");
        do_ertn();
        rd(14'h000, 32'h0000_0007, "ertn_crmd");

        // Same-cycle software ERA write loses to exception
        we = 1'b1; waddr = 14'h006; wdata = 32'h0000_1234;
        va_error = 1'b1; bad_va = 32'hDEAD_0000;
        do_excp(6'h0B, 32'h0000_5678);
        we = 1'b0; va_error = 1'b0;
        rd(14'h006, 32'h0000_5678, "era_excp_wins");
        rd(14'h007, 32'hDEAD_0000, "badv_update");
        do_ertn();

        // TLB refill entry and ERTN from it
        excp_tlbrefill = 1'b1; excp_tlb = 1'b1; excp_tlb_vppn = 19'h12345;
        do_excp(6'h3F, 32'h1C00_0200);
        excp_tlbrefill = 1'b0; excp_tlb = 1'b0;
        rd(14'h000, 32'h0000_0008, "refill_crmd");
        rd(14'h011, 32'h2468_A000, "refill_tlbehi");
        rd(14'h005, 32'h003F_0000, "refill_estat");
        do_ertn();
        rd(14'h000, 32'h0000_0017, "refill_ertn_crmd");

        // Exception and ERTN together: exception wins
        ertn_flush = 1'b1;
        do_excp(6'h3F, 32'h1C00_0300);
        ertn_flush = 1'b0;
        rd(14'h000, 32'h0000_0010, "excp_over_ertn");
        do_ertn();
        rd(14'h000, 32'h0000_0017, "ertn_restore");

        // Write masks
        wr(14'h00C, 32'hFFFF_FFFF);
        expect_out(SEL_EENTRY, 14'h000, 32'hFFFF_FFC0, "eentry_mask");
        wr(14'h7FF, 32'hFFFF_FFFF);
        rd(14'h7FF, 32'h0000_0000, "unmapped_write");
        wr(14'h005, 32'hFFFF_FFFF);
        rd(14'h005, 32'h003F_0003, "estat_mask");
        wr(14'h005, 32'h0000_0000);
        wr(14'h004, 32'hFFFF_FFFF);
        rd(14'h004, 32'h0000_1BFF, "ecfg_mask");
        wr(14'h030, 32'hA5A5_5A5A);
        rd(14'h030, 32'hA5A5_5A5A, "save0");
        wr(14'h042, 32'h0000_0123);
        rd(14'h042, 32'h0000_0000, "tval_readonly");

        // Interrupt line sampling
        hw_int = 8'h81; ipi = 1'b1;
        step();
        rd(14'h005, 32'h003F_1204, "is_sampling");
        expect_out(SEL_HASINT, 14'h000, 32'h1, "has_int_hw");
        hw_int = 8'h00; ipi = 1'b0;
        step();
        expect_out(SEL_HASINT, 14'h000, 32'h0, "has_int_clear");

        // One-shot timer: InitVal=4 -> TVAL 16, IS[11] 16 edges after the write
        wr(14'h041, 32'h0000_0011);
        repeat (15) step();
        rd(14'h005, 32'h003F_0000, "oneshot_before");
        rd(14'h005, 32'h003F_0800, "oneshot_set");
        rd(14'h042, 32'h0000_0000, "oneshot_tval_hold");
        expect_out(SEL_HASINT, 14'h000, 32'h1, "timer_has_int");
        wr(14'h044, 32'h0000_0001);
        expect_out(SEL_HASINT, 14'h000, 32'h0, "ticlr_has_int");
        rd(14'h044, 32'h0000_0000, "ticlr_read");
        rd(14'h042, 32'h0000_0000, "oneshot_tval_idle");

        // Periodic timer: InitVal=2 -> TVAL 8, IS[11] every 9 edges
        wr(14'h041, 32'h0000_000B);
        repeat (7) step();
        rd(14'h005, 32'h003F_0000, "periodic_before");
        rd(14'h005, 32'h003F_0800, "periodic_set1");
        wr(14'h044, 32'h0000_0001);
        rd(14'h005, 32'h003F_0000, "periodic_cleared");
        repeat (5) step();
        wr(14'h044, 32'h0000_0001);
        rd(14'h005, 32'h003F_0800, "set_beats_ticlr");
        rd(14'h042, 32'h0000_0008, "periodic_reload");
        wr(14'h041, 32'h0000_0000);
        wr(14'h044, 32'h0000_0001);
        rd(14'h005, 32'h003F_0000, "timer_stopped");

        // En=1 with InitVal=0: idle, no interrupt
        wr(14'h041, 32'h0000_0001);
        repeat (3) step();
        rd(14'h005, 32'h003F_0000, "zero_init_no_int");
        rd(14'h042, 32'h0000_0000, "zero_init_tval");
        rd(14'h041, 32'h0000_0001, "tcfg_read");

        // LL bit and KLO
        llbit_we = 1'b1; llbit_value = 1'b1;
        step();
        llbit_we = 1'b0; llbit_value = 1'b0;
        expect_out(SEL_LLBIT, 14'h000, 32'h1, "llbit_set");
        wr(14'h060, 32'h0000_0004);
        rd(14'h060, 32'h0000_0005, "llbctl_klo");
        do_ertn();
        rd(14'h060, 32'h0000_0001, "ertn_klo_keeps");
        do_ertn();
        rd(14'h060, 32'h0000_0000, "ertn_clears_llbit");
        expect_out(SEL_LLBIT, 14'h000, 32'h0, "llbit_o_clear");
        llbit_we = 1'b1; llbit_value = 1'b1;
        step();
        llbit_we = 1'b0; llbit_value = 1'b0;
        wr(14'h060, 32'h0000_0002);
        rd(14'h060, 32'h0000_0000, "llbctl_sw_clear");

        step();
        n_total++;
        if (q_sel.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d pending, required 0", q_sel.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
